vga_timing_gen: RTL

//  Parametrised VGA raster timing generator with a built-in test-pattern source.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_if.sv | 31 +++
 rtl/vga_pattern.sv | 47 ++++
 rtl/vga_timing_gen.sv | 99 +++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing defaults, test-pattern mode encodings and colour level helpers
package vga_pkg;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic [1:0] {
        MODE_BLACK = 2'd0,
        MODE_SKY   = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    function automatic int lvl_full(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic int lvl_half(input int w);
        return 1 << (w - 1);
    endfunction
endpackage

// File: rtl/vga_if.sv
// vga_if: pixel strobe / mode inputs and raster + colour outputs of the timing generator
interface vga_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int COLOR_W = 4
);
    logic               i_pix_en;
    logic [1:0]         i_mode;
    logic               o_hsync;
    logic               o_vsync;
    logic               o_de;
    logic [X_W-1:0]     o_x;
    logic [Y_W-1:0]     o_y;
    logic               o_frame_start;
    logic               o_line_start;
    logic [COLOR_W-1:0] o_red;
    logic [COLOR_W-1:0] o_green;
    logic [COLOR_W-1:0] o_blue;

    modport master (
        input  i_pix_en, i_mode,
        output o_hsync, o_vsync, o_de, o_x, o_y, o_frame_start, o_line_start,
               o_red, o_green, o_blue
    );

    modport slave (
        output i_pix_en, i_mode,
        input  o_hsync, o_vsync, o_de, o_x, o_y, o_frame_start, o_line_start,
               o_red, o_green, o_blue
    );
endinterface

// File: rtl/vga_pattern.sv
// vga_pattern: combinational test-pattern colour for raster position (hc,vc) under a given mode
module vga_pattern
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int COLOR_W  = 4
) (
    input  mode_e              mode,
    input  logic [X_W-1:0]     hc,
    input  logic [Y_W-1:0]     vc,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);
    localparam logic [COLOR_W-1:0] FULL = COLOR_W'(lvl_full(COLOR_W));
    localparam logic [COLOR_W-1:0] HALF = COLOR_W'(lvl_half(COLOR_W));
    localparam logic [31:0] MID   = 32'(H_ACTIVE / 2);
    localparam logic [31:0] HORIZ = 32'(V_ACTIVE / 2);

    logic [31:0] hx, vx;
    logic [2:0]  bar;
    logic        sky, dash, chk;

    always_comb begin
        hx  = 32'(hc);
        vx  = 32'(vc);
        bar = '0;
        for (int k = 1; k < 8; k++)
            if (hx >= 32'(k * H_ACTIVE / 8)) bar = 3'(k);
        sky  = vx < HORIZ;
        // |hc - MID| < 4 rewritten so no negative intermediate appears
        dash = vx[4] && (hx + 32'd4 > MID) && (hx < MID + 32'd4);
        chk  = hx[5] ^ vx[5];
        red   = mode == MODE_SKY   ? (sky ? '0 : dash ? FULL : HALF) :
                mode == MODE_BARS  ? (bar[1] ? '0 : FULL) :
                mode == MODE_CHECK ? (chk ? FULL : '0) : '0;
        green = mode == MODE_SKY   ? (dash && !sky ? FULL : HALF) :
                mode == MODE_BARS  ? (bar[2] ? '0 : FULL) :
                mode == MODE_CHECK ? (chk ? FULL : '0) : '0;
        blue  = mode == MODE_SKY   ? (sky || dash ? FULL : HALF) :
                mode == MODE_BARS  ? (bar[0] ? '0 : FULL) :
                mode == MODE_CHECK ? (chk ? FULL : '0) : '0;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster counters, registered sync/de/coords/strobes and test-pattern RGB
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int COLOR_W  = 4
) (
    input logic   clk,
    input logic   rst,
    vga_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [31:0] H_LAST = 32'(H_TOTAL - 1);
    localparam logic [31:0] V_LAST = 32'(V_TOTAL - 1);
    localparam logic [31:0] HS_B   = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_E   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_B   = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_E   = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [X_W-1:0]     hc;
    logic [Y_W-1:0]     vc;
    mode_e              mode_q;
    logic [31:0]        hx, vx;
    logic               h_last, v_last, hs_on, vs_on, de_n;
    logic [COLOR_W-1:0] pr, pg, pb;

    always_comb begin
        hx     = 32'(hc);
        vx     = 32'(vc);
        h_last = hx == H_LAST;
        v_last = vx == V_LAST;
        hs_on  = hx >= HS_B && hx < HS_E;
        vs_on  = vx >= VS_B && vx < VS_E;
        de_n   = hx < 32'(H_ACTIVE) && vx < 32'(V_ACTIVE);
    end

    vga_pattern #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .COLOR_W (COLOR_W)
    ) u_pattern (
        .mode (mode_q),
        .hc   (hc),
        .vc   (vc),
        .red  (pr),
        .green(pg),
        .blue (pb)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            hc                <= '0;
            vc                <= '0;
            mode_q            <= MODE_BLACK;
            vga.o_hsync       <= ~HS_POL;
            vga.o_vsync       <= ~VS_POL;
            vga.o_de          <= 1'b0;
            vga.o_x           <= '0;
            vga.o_y           <= '0;
            vga.o_frame_start <= 1'b0;
            vga.o_line_start  <= 1'b0;
            vga.o_red         <= '0;
            vga.o_green       <= '0;
            vga.o_blue        <= '0;
        end else if (vga.i_pix_en) begin
            hc                <= h_last ? '0 : hc + 1'b1;
            vc                <= h_last ? (v_last ? '0 : vc + 1'b1) : vc;
            // shadow only at the last pixel of a frame so a mode change never tears
            mode_q            <= (h_last && v_last) ? mode_e'(vga.i_mode) : mode_q;
            vga.o_hsync       <= hs_on ? HS_POL : ~HS_POL;
            vga.o_vsync       <= vs_on ? VS_POL : ~VS_POL;
            vga.o_de          <= de_n;
            vga.o_x           <= hc;
            vga.o_y           <= vc;
            vga.o_frame_start <= hx == 32'd0 && vx == 32'd0;
            vga.o_line_start  <= hx == 32'd0 && vx < 32'(V_ACTIVE);
            vga.o_red         <= de_n ? pr : '0;
            vga.o_green       <= de_n ? pg : '0;
            vga.o_blue        <= de_n ? pb : '0;
        end else begin
            vga.o_frame_start <= 1'b0;
            vga.o_line_start  <= 1'b0;
        end
    end
endmodule
